// File: rtl/am_trainer.sv
// Trains one language prototype: per-bit majority vote over text hypervectors, then streams it word by word.
// Writes start the cycle after finish (one word per cycle, no stall input); done pulses one cycle after the last word.
module am_trainer #(
  parameter int N           = 10000,
  parameter int NUMLANG     = 22,
  parameter int LOG_NUMLANG = $clog2(NUMLANG),
  parameter int CNT_W       = 16,
  parameter int WORD_W      = 100,
  parameter int NUM_WORDS   = N / WORD_W,
  parameter int WADDR_W     = $clog2(NUM_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LOG_NUMLANG-1:0] langID,
  input  logic                   vecValid,
  input  logic [N-1:0]           textVector,
  input  logic                   finish,
  output logic                   busy,
  output logic                   amWrite,
  output logic [LOG_NUMLANG-1:0] amLang,
  output logic [WADDR_W-1:0]     amWordAddr,
  output logic [WORD_W-1:0]      amData,
  output logic                   saturated,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [WADDR_W-1:0] LAST_WORD = WADDR_W'(NUM_WORDS - 1);

  state_t           state;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] acc [N];
  logic [N-1:0]     proto;
  logic [WORD_W-1:0] words [NUM_WORDS];

  wire start_acc = (state == IDLE) && start;
  // A full sample counter freezes accumulation, so no accumulator can ever wrap.
  wire take_vec  = (state == ACCUM) && vecValid && (sample_cnt != CNT_MAX);

  for (genvar g = 0; g < N; g++) begin : g_acc
    always_ff @(posedge clk) begin
      if (start_acc)
        acc[g] <= '0;
      else if (take_vec)
        acc[g] <= acc[g] + CNT_W'(textVector[g]);
    end
    // Strict majority: 2*acc > count, one extra bit so the doubling cannot overflow.
    assign proto[g] = {acc[g], 1'b0} > {1'b0, sample_cnt};
  end

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    assign words[w] = proto[w*WORD_W +: WORD_W];
  end

  // Data follows the registered address, so a vector counted alongside finish is already in acc.
  assign amData = amWrite ? words[amWordAddr] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      amWrite    <= 1'b0;
      amLang     <= '0;
      amWordAddr <= '0;
      saturated  <= 1'b0;
      done       <= 1'b0;
      sample_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            amLang     <= langID;
            sample_cnt <= '0;
            saturated  <= 1'b0;
            busy       <= 1'b1;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          if (take_vec) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == CNT_MAX - 1'b1)
              saturated <= 1'b1;
          end
          if (finish) begin
            amWrite    <= 1'b1;
            amWordAddr <= '0;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (amWordAddr == LAST_WORD) begin
            amWrite    <= 1'b0;
            amWordAddr <= '0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            amWordAddr <= amWordAddr + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_am_trainer.sv
// Scoreboard bench for am_trainer at N=8, WORD_W=4, CNT_W=3 (two words per prototype).
module tb_am_trainer;

  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] langID;
  logic          vecValid;
  logic [7:0]    textVector;
  logic          finish;
  logic          busy;
  logic          amWrite;
  logic [LW-1:0] amLang;
  logic [0:0]    amWordAddr;
  logic [3:0]    amData;
  logic          saturated;
  logic          done;

  am_trainer #(.N(8), .WORD_W(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .langID(langID),
    .vecValid(vecValid), .textVector(textVector), .finish(finish),
    .busy(busy), .amWrite(amWrite), .amLang(amLang), .amWordAddr(amWordAddr),
    .amData(amData), .saturated(saturated), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_done;
    logic [LW-1:0] lang;
    logic [0:0]    addr;
    logic [3:0]    data;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write or done the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (amWrite === 1'b1 || done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: amWrite=%0b done=%0b addr=%0h data=%0h, expected none (cycle %0d)",
                   amWrite, done, amWordAddr, amData, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("kind", {30'd0, amWrite, done}, e.is_done ? 32'd1 : 32'd2);
          chk("when", cyc, e.cyc);
          chk("busy_out", busy, 1'b1);
          if (!e.is_done) begin
            chk("amLang", amLang, e.lang);
            chk("amWordAddr", amWordAddr, e.addr);
            chk("amData", amData, e.data);
          end
        end
      end else if (amWrite === 1'b0) begin
        chk("idle_bus", {amWordAddr, amData}, 5'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [LW-1:0] lang, input logic [0:0] addr, input logic [3:0] data, input int c);
    exp_t e;
    e.is_done = 1'b0; e.lang = lang; e.addr = addr; e.data = data; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_d(input int c);
    exp_t e;
    e.is_done = 1'b1; e.lang = '0; e.addr = '0; e.data = '0; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [LW-1:0] lang);
    start = 1'b1; langID = lang;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("lang_latched", amLang, lang);
  endtask

  task automatic send_vec(input logic [7:0] v);
    vecValid = 1'b1; textVector = v;
    tick();
    vecValid = 1'b0; textVector = '0;
  endtask

  // Finish with optional same-cycle vector; expect two words then done.
  task automatic do_finish(input logic [LW-1:0] lang, input logic [3:0] w0, input logic [3:0] w1,
                           input bit with_vec, input logic [7:0] v);
    int t;
    t = cyc;
    push_w(lang, 1'b0, w0, t + 1);
    push_w(lang, 1'b1, w1, t + 2);
    push_d(t + 3);
    finish = 1'b1; vecValid = with_vec; textVector = v;
    tick();
    finish = 1'b0; vecValid = 1'b0; textVector = '0;
    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; langID = '0; vecValid = 1'b0; textVector = '0; finish = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #4;
    chk("rst_outputs", {busy, amWrite, done, saturated, amLang, amWordAddr, amData}, 0);
    mon_en = 1'b1;
    tick();

    // finish outside ACCUM is ignored
    finish = 1'b1; tick(); finish = 1'b0;
    repeat (3) tick();
    chk("idle_finish_busy", busy, 1'b0);

    // majority 0xFF,0x0F,0x03 -> word0 F, word1 0
    do_start(5'd5);
    send_vec(8'hFF); send_vec(8'h0F); send_vec(8'h03);
    do_finish(5'd5, 4'hF, 4'h0, 1'b0, 8'h00);
    chk("sat_clear", saturated, 1'b0);

    // ties give zero
    do_start(5'd3);
    send_vec(8'hF0); send_vec(8'h0F);
    do_finish(5'd3, 4'h0, 4'h0, 1'b0, 8'h00);

    // no samples
    do_start(5'd7);
    do_finish(5'd7, 4'h0, 4'h0, 1'b0, 8'h00);

    // saturation: seventh vector fills the counter, eighth ignored
    do_start(5'd2);
    for (int i = 0; i < 6; i++) send_vec(8'h01);
    chk("sat_before", saturated, 1'b0);
    send_vec(8'h01);
    chk("sat_at_7", saturated, 1'b1);
    send_vec(8'h01);
    do_finish(5'd2, 4'h1, 4'h0, 1'b0, 8'h00);
    chk("sat_sticky", saturated, 1'b1);

    // reset during the first write
    do_start(5'd4);
    chk("sat_cleared_by_start", saturated, 1'b0);
    send_vec(8'h01);
    begin
      int t;
      t = cyc;
      push_w(5'd4, 1'b0, 4'h1, t + 1);
      finish = 1'b1; tick(); finish = 1'b0;
      rst = 1'b0; tick(); rst = 1'b1;
      chk("rst_mid_write", {busy, amWrite, done, saturated, amLang}, 0);
      repeat (4) tick();
      chk("rst_queue", exp_q.size(), 0);
    end
    do_start(5'd6);
    send_vec(8'h80);
    do_finish(5'd6, 4'h0, 4'h8, 1'b0, 8'h00);

    // start while busy is ignored; vector with finish counted first
    do_start(5'd9);
    start = 1'b1; langID = 5'd1; tick(); start = 1'b0;
    chk("lang_hold", amLang, 5'd9);
    do_finish(5'd9, 4'h1, 4'h0, 1'b1, 8'h01);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/am_trainer.md
AM_TRAINER -- requirements
Module: am_trainer

Interface
REQ-001: Parameter N, default 10000, hypervector dimension in bits.
REQ-002: Parameter NUMLANG, default 22, number of language prototypes in associative memory.
REQ-003: Parameter LOG_NUMLANG, default $clog2(NUMLANG), language ID width.
REQ-004: Parameter CNT_W, default 16, width of each per-bit accumulator and of the sample counter.
REQ-005: Parameter WORD_W, default 100, associative-memory write word width; N SHALL be an integer multiple of WORD_W.
REQ-006: Parameter NUM_WORDS, default N/WORD_W, words per prototype; WADDR_W, default $clog2(NUM_WORDS).
REQ-007: clk  input  1  single clock; all state changes on rising edge.
REQ-008: rst  input  1  synchronous, active-low reset.
REQ-009: start  input  1  one-cycle pulse that begins training for langID.
REQ-010: langID  input  LOG_NUMLANG  target language, sampled only when start is accepted.
REQ-011: vecValid  input  1  textVector holds one completed text hypervector this cycle.
REQ-012: textVector  input  N  binary text hypervector from the random-index encoder.
REQ-013: finish  input  1  end of training set for current language.
REQ-014: busy  output  1  high from start acceptance until done cycle inclusive.
REQ-015: amWrite  output  1  write strobe to associative memory.
REQ-016: amLang  output  LOG_NUMLANG  prototype row being written.
REQ-017: amWordAddr  output  WADDR_W  word index within the row.
REQ-018: amData  output  WORD_W  prototype bits [amWordAddr*WORD_W +: WORD_W].
REQ-019: saturated  output  1  sticky: sample counter reached 2^CNT_W-1 during current training.
REQ-020: done  output  1  one-cycle pulse after last word written.

Function
REQ-021: FSM states IDLE, ACCUM, WRITE, DONE; reset state IDLE.
REQ-022: IDLE: start=1 -> latch langID into amLang, clear all N accumulators, sample counter and saturated, go ACCUM next cycle, busy=1 from next cycle.
REQ-023: start SHALL be ignored in any state other than IDLE.
REQ-024: ACCUM: vecValid=1 -> each accumulator i adds textVector[i], sample counter +1.
REQ-025: vecValid SHALL be ignored outside ACCUM.
REQ-026: Sample counter at 2^CNT_W-1 -> further vecValid ignored entirely (no accumulator or counter change), saturated=1 until next start or reset.
REQ-027: Accumulators cannot exceed sample counter, hence never overflow.
REQ-028: ACCUM with finish=1 -> WRITE next cycle; vecValid in the same cycle SHALL be counted first.
REQ-029: Prototype bit i = 1 iff 2*acc[i] > sampleCount (strict majority; ties and zero samples give 0), computed at CNT_W+1 bits.
REQ-030: WRITE: amWrite=1 each cycle, amWordAddr = 0,1,...,NUM_WORDS-1 in consecutive cycles, amData = corresponding thresholded word, amLang constant.
REQ-031: After word NUM_WORDS-1 -> DONE; DONE asserts done=1 for exactly one cycle with busy=1, then IDLE (busy=0).
REQ-032: Latency: finish at cycle t -> first amWrite at t+1, last at t+NUM_WORDS, done at t+NUM_WORDS+1.
REQ-033: amWrite SHALL be 0 in IDLE, ACCUM, DONE; amData and amWordAddr SHALL be 0 when amWrite=0.
REQ-034: finish outside ACCUM SHALL be ignored.

Reset
REQ-035: rst=0 at a rising edge -> state IDLE, busy, amWrite, done, saturated, amWordAddr, amData, amLang, sample counter = 0 next cycle, in any state, including mid-WRITE (no further writes, no done).
REQ-036: Accumulator contents need not be reset; they SHALL be cleared on start acceptance.

Verification (N=8, WORD_W=4, CNT_W=3)
REQ-037: start langID=5; vectors 0xFF,0x0F,0x03; finish -> writes addr0 data 0xF, addr1 data 0x0, amLang=5, done one cycle after addr1.
REQ-038: vectors 0xF0,0x0F; finish -> ties -> both words 0x0.
REQ-039: start then immediate finish, no vectors -> two writes of 0x0, done at t+3.
REQ-040: eight vectors 0x01 -> seventh saturates counter, eighth ignored, saturated=1; prototype words 0x1, 0x0.
REQ-041: rst=0 during addr0 write -> next cycle amWrite=0, busy=0, no done; subsequent start trains normally.
REQ-042: start while busy ignored (amLang unchanged); vecValid=1 with finish=1 (vector 0x01, only sample) -> words 0x1, 0x0.
